// File: rtl/clkgen_pkg.sv
// Shared defaults and watchdog state encoding for the multi-channel tick generator.
package clkgen_pkg;
    localparam int DIV_W_DEF = 16;
    localparam int TMO_W_DEF = 32;

    localparam logic [1:0] WD_IDLE = 2'd0;
    localparam logic [1:0] WD_RUN  = 2'd1;
    localparam logic [1:0] WD_DONE = 2'd2;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: programmable half-period, 50% square wave, tick on each rising edge.
module clk_div_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] half_div_i,
    input  logic             load_i,
    output logic             clk_out_o,
    output logic             tick_o
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] sh_q, sh_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             boundary;

    assign boundary = (cnt_q == act_q - ONE);

    // The active ratio only follows the shadow at a half-period boundary (or while
    // disabled), so a mid-period reload never shortens the half in progress.
    always_comb begin
        sh_d   = sh_q;
        act_d  = act_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (load_i)
            sh_d = (half_div_i == '0) ? ONE : half_div_i;
        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            act_d = sh_q;
        end else if (boundary) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            act_d  = sh_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= ONE;
            sh_q   <= ONE;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/multi_clk_tick_gen.sv
// N divider channels plus a run-length watchdog that flags done after tmo_limit cycles.
module multi_clk_tick_gen
    import clkgen_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DIV_W = DIV_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       ch_en,
    input  logic [CH*DIV_W-1:0] half_div,
    input  logic [CH-1:0]       div_load,
    output logic [CH-1:0]       clk_out,
    output logic [CH-1:0]       tick,
    input  logic [TMO_W-1:0]    tmo_limit,
    input  logic                tmo_start,
    output logic                tmo_run,
    output logic                tmo_done
);
    localparam logic [TMO_W-1:0] ONE_T = TMO_W'(1);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_div_chan #(.DIV_W(DIV_W)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (ch_en[i]),
            .half_div_i (half_div[i*DIV_W +: DIV_W]),
            .load_i     (div_load[i]),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i])
        );
    end

    logic [1:0]       st_q, st_d;
    logic [TMO_W-1:0] wcnt_q, wcnt_d;

    // Limit is compared live; a limit of zero completes on the first RUN cycle.
    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        if (tmo_start) begin
            st_d   = WD_RUN;
            wcnt_d = '0;
        end else if (st_q == WD_RUN) begin
            if (tmo_limit == '0 || wcnt_q == tmo_limit - ONE_T)
                st_d = WD_DONE;
            else
                wcnt_d = wcnt_q + ONE_T;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= WD_IDLE;
            wcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign tmo_run  = (st_q == WD_RUN);
    assign tmo_done = (st_q == WD_DONE);
endmodule

// File: tb/tb_multi_clk_tick_gen.sv
// Directed bench for multi_clk_tick_gen: dividers, reload timing, watchdog latency, reset.
module tb_multi_clk_tick_gen;
    localparam int CH = 4, DIV_W = 16, TMO_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH-1:0]       ch_en;
    logic [CH*DIV_W-1:0] half_div;
    logic [CH-1:0]       div_load;
    logic [CH-1:0]       clk_out, tick;
    logic [TMO_W-1:0]    tmo_limit;
    logic                tmo_start;
    logic                tmo_run, tmo_done;

    int checks = 0;
    int failures = 0;

    multi_clk_tick_gen #(.CH(CH), .DIV_W(DIV_W), .TMO_W(TMO_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .half_div  (half_div),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .tmo_limit (tmo_limit),
        .tmo_start (tmo_start),
        .tmo_run   (tmo_run),
        .tmo_done  (tmo_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100us;
        $display("FAIL global_timeout: simulation exceeded time cap");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hd(input int ch, input logic [DIV_W-1:0] v);
        half_div[ch*DIV_W +: DIV_W] = v;
    endtask

    initial begin
        logic e_c, e_t, e_c2, e_t2, e_c3, e_t3;
        int n;

        // 1: reset with every input active
        rst_n = 1'b0; ch_en = '1; half_div = {4{16'd5}}; div_load = '1;
        tmo_limit = 32'd3; tmo_start = 1'b1;
        cyc(3);
        chk("rst_outs", {clk_out, tick, tmo_run, tmo_done}, 64'h0);
        div_load = '0; tmo_start = 1'b0; ch_en = 4'b0001;
        cyc(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            e_c = k[0];
            chk("rst_div1", {clk_out, tick}, {3'b0, e_c, 3'b0, e_c});
        end

        // 2: ch0 half period 5
        ch_en = '0; set_hd(0, 16'd5); div_load = 4'b0001;
        cyc(1);
        div_load = '0;
        cyc(1);
        chk("t2_idle", {clk_out, tick}, 64'h0);
        ch_en = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            e_c = ((k / 5) % 2) == 1;
            e_t = (k % 10) == 5;
            chk("t2_div5", {clk_out, tick}, {3'b0, e_c, 3'b0, e_t});
        end

        // 3: ch1 at 3, reload 7 mid-period, then reload 2 exactly on a boundary
        ch_en = '0; set_hd(1, 16'd3); div_load = 4'b0010;
        cyc(1);
        div_load = '0;
        cyc(1);
        ch_en = 4'b0010;
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin
                set_hd(1, 16'd7); div_load = 4'b0010;
            end else if (k == 13) begin
                set_hd(1, 16'd2); div_load = 4'b0010;
            end else begin
                div_load = '0;
            end
            cyc(1);
            e_c = (k >= 3 && k < 6) || (k >= 13 && k < 20) || (k >= 22 && k < 24);
            e_t = (k == 3) || (k == 13) || (k == 22);
            chk("t3_reload", {clk_out, tick}, {2'b0, e_c, 1'b0, 2'b0, e_t, 1'b0});
        end
        div_load = '0;

        // 4: ch2 loaded with 0 (acts as 1), ch3 at 3, enabled together
        ch_en = '0; set_hd(2, 16'd0); set_hd(3, 16'd3); div_load = 4'b1100;
        cyc(1);
        div_load = '0;
        cyc(1);
        ch_en = 4'b1100;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            e_c2 = k[0]; e_t2 = k[0];
            e_c3 = ((k / 3) % 2) == 1;
            e_t3 = (k % 6) == 3;
            chk("t4_pair", {clk_out, tick}, {e_c3, e_c2, 2'b0, e_t3, e_t2, 2'b0});
        end

        // 5: watchdog latency, stickiness, restart, zero limit
        ch_en = '0; tmo_limit = 32'd50; tmo_start = 1'b1;
        cyc(1);
        tmo_start = 1'b0;
        chk("wd_start", {tmo_run, tmo_done}, 2'b10);
        n = 0;
        while (!tmo_done && n < 100) begin cyc(1); n++; end
        chk("wd_lat50", n, 50);
        chk("wd_done", {tmo_run, tmo_done}, 2'b01);
        cyc(5);
        chk("wd_sticky", {tmo_run, tmo_done}, 2'b01);
        tmo_start = 1'b1;
        cyc(1);
        tmo_start = 1'b0;
        chk("wd_clr", {tmo_run, tmo_done}, 2'b10);
        cyc(19);
        tmo_start = 1'b1;
        cyc(1);
        tmo_start = 1'b0;
        n = 0;
        while (!tmo_done && n < 100) begin cyc(1); n++; end
        chk("wd_restart", n, 50);
        tmo_limit = 32'd0; tmo_start = 1'b1;
        cyc(1);
        tmo_start = 1'b0;
        chk("wd_lim0_a", {tmo_run, tmo_done}, 2'b10);
        cyc(1);
        chk("wd_lim0_b", {tmo_run, tmo_done}, 2'b01);

        // 6: async reset while running
        set_hd(0, 16'd4); div_load = 4'b0001;
        cyc(1);
        div_load = '0;
        cyc(1);
        ch_en = 4'b0001; tmo_limit = 32'd50; tmo_start = 1'b1;
        cyc(1);
        tmo_start = 1'b0;
        cyc(4);
        chk("t6_pre", {clk_out[0], tmo_run}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t6_async", {clk_out, tick, tmo_run, tmo_done}, 64'h0);
        ch_en = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("t6_post", {clk_out, tick, tmo_run, tmo_done}, 64'h0);
        div_load = 4'b0001;
        cyc(1);
        div_load = '0;
        cyc(1);
        ch_en = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            e_c = ((k / 4) % 2) == 1;
            e_t = (k == 4);
            chk("t6_reprog", {clk_out, tick}, {3'b0, e_c, 3'b0, e_t});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
